instr_sequencer: RTL and testbench

- Drives the multicycle processor's DIN/Run/Done interface from the issuing side.
- Holds a small program memory, loaded word by word while idle.
- On start, issues one instruction at a time: presents the instruction word, pulses Run, supplies the immediate word for mvi, then waits for Done before advancing.
- Sits between the board/testbench stimulus and the processor, replacing hand-driven DIN switches.

---
 rtl/instr_sequencer_pkg.sv | 27 ++
 rtl/instr_sequencer_if.sv | 31 +++
 rtl/instr_sequencer_prog_mem.sv | 21 ++
 rtl/instr_sequencer.sv | 152 +++++++++++++++
 tb/tb_instr_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for instr_sequencer: processor opcode encoding and the
// state encoding of the sequencer FSM.
package instr_sequencer_pkg;

   localparam int OPC_HI = 8;
   localparam int OPC_LO = 6;

   typedef enum logic [2:0] {
      OP_MV  = 3'b000,
      OP_MVI = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE    = 3'd1,
      S_IMM      = 3'd2,
      S_WAIT     = 3'd3,
      S_FINISHED = 3'd4
   } seq_state_e;

   function automatic logic is_mvi(input logic [2:0] opc);
      return opc == OP_MVI;
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the stimulus side (slave: program load, start, status) and the
// sequencer (master: drives DIN/Run and status, consumes Done from the processor).
interface instr_sequencer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic              start;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_wdata;
   logic [ADDR_W:0]   prog_len;
   logic              Done;
   logic [DATA_W-1:0] DIN;
   logic              Run;
   logic              busy;
   logic              halted;
   logic              err_mvi;
   logic              timeout;
   logic [ADDR_W:0]   pc;
   logic [15:0]       instr_count;

   modport master (
      input  start, prog_we, prog_addr, prog_wdata, prog_len, Done,
      output DIN, Run, busy, halted, err_mvi, timeout, pc, instr_count
   );

   modport slave (
      output start, prog_we, prog_addr, prog_wdata, prog_len, Done,
      input  DIN, Run, busy, halted, err_mvi, timeout, pc, instr_count
   );
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// seq_prog_mem: program store, 2**ADDR_W x DATA_W, synchronous write and
// combinational read so the addressed word is on DIN in the same cycle.
module seq_prog_mem #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues a stored program to the processor over DIN/Run/Done, one instruction at a time,
// stalling on Done indefinitely, or for at most WDT_CYCLES when SEQ_WATCHDOG_EN is defined.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 16,
   parameter int WDT_CYCLES = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   instr_sequencer_if.master  bus
);
   seq_state_e        state_q, state_d;
   logic [ADDR_W:0]   pc_q, pc_d, pc_next;
   logic [15:0]       cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] din;
   logic              run;
   logic              mem_we;
   logic              launch;
   logic              complete;
   logic              last_word;
   logic              wdt_fire;

   // Loading is only allowed while nothing is executing so DIN stays stable in WAIT.
   assign mem_we = bus.prog_we && (state_q == S_IDLE || state_q == S_FINISHED);

   seq_prog_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
      .clk_i   (Clock),
      .we_i    (mem_we),
      .waddr_i (bus.prog_addr),
      .wdata_i (bus.prog_wdata),
      .raddr_i (pc_q[ADDR_W-1:0]),
      .rdata_o (mem_rdata)
   );

   assign pc_next   = pc_q + 1'b1;
   assign last_word = pc_next >= bus.prog_len;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      din      = '0;
      run      = 1'b0;
      launch   = 1'b0;
      complete = 1'b0;
      case (state_q)
         S_IDLE, S_FINISHED: begin
            if (bus.start) begin
               launch  = 1'b1;
               pc_d    = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = (bus.prog_len == '0) ? S_FINISHED : S_ISSUE;
            end
         end
         S_ISSUE: begin
            din = mem_rdata;
            if (is_mvi(mem_rdata[OPC_HI:OPC_LO])) begin
               // An mvi with no following word would feed garbage as its immediate.
               if (last_word) begin
                  err_d   = 1'b1;
                  state_d = S_FINISHED;
               end else begin
                  run     = 1'b1;
                  pc_d    = pc_next;
                  state_d = S_IMM;
               end
            end else begin
               run     = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_IMM: begin
            din = mem_rdata;
            if (bus.Done) complete = 1'b1;
            else          state_d  = S_WAIT;
         end
         S_WAIT: begin
            din = mem_rdata;
            if (bus.Done)     complete = 1'b1;
            else if (wdt_fire) state_d = S_FINISHED;
         end
         default: state_d = S_IDLE;
      endcase
      if (complete) begin
         pc_d    = pc_next;
         cnt_d   = (cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
         state_d = last_word ? S_FINISHED : S_ISSUE;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

`ifdef SEQ_WATCHDOG_EN
   localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   logic [WDT_W-1:0] wdt_q, wdt_d;
   logic             timeout_q, timeout_d;

   assign wdt_fire = (state_q == S_WAIT) && !bus.Done && (wdt_q == WDT_W'(WDT_CYCLES - 1));

   always_comb begin
      wdt_d     = '0;
      timeout_d = timeout_q;
      // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
      if (state_q == S_WAIT && !bus.Done) wdt_d = wdt_q + WDT_W'(1);
      if (launch)        timeout_d = 1'b0;
      else if (wdt_fire) timeout_d = 1'b1;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wdt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdt_q     <= wdt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   logic unused_wdt_cfg;
   assign unused_wdt_cfg = (WDT_CYCLES != 0);
   assign wdt_fire       = 1'b0;
   assign bus.timeout    = 1'b0;
`endif

   assign bus.DIN         = din;
   assign bus.Run         = run;
   assign bus.busy        = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);
   assign bus.halted      = (state_q == S_FINISHED);
   assign bus.err_mvi     = err_q;
   assign bus.pc          = pc_q;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small behavioural processor on DIN/Run/Done
// (mv/mvi finish one cycle after Run, add/sub two cycles after Run).
module tb_instr_sequencer;
   logic clk = 1'b0;
   logic rst;
   logic hang;
   int   checks = 0;
   int   errors = 0;

   instr_sequencer_if #(.ADDR_W(5), .DATA_W(16)) bus ();

   instr_sequencer #(.ADDR_W(5), .DATA_W(16), .WDT_CYCLES(8)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Processor model: latches IR on Run, completes with a combinational Done.
   logic [15:0] R [8];
   logic [8:0]  ir;
   logic        active;
   logic [1:0]  step;

   assign bus.Done = active && !hang && ((ir[8:7] == 2'b00) ? (step == 2'd1) : (step == 2'd2));

   always @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         step   <= 2'd0;
         ir     <= '0;
         for (int i = 0; i < 8; i++) R[i] <= '0;
      end else if (bus.Run) begin
         ir     <= bus.DIN[8:0];
         active <= 1'b1;
         step   <= 2'd1;
      end else if (active) begin
         if (bus.Done) begin
            case (ir[8:6])
               3'b000:  R[ir[5:3]] <= R[ir[2:0]];
               3'b001:  R[ir[5:3]] <= bus.DIN;
               3'b010:  R[ir[5:3]] <= R[ir[5:3]] + R[ir[2:0]];
               3'b011:  R[ir[5:3]] <= R[ir[5:3]] - R[ir[2:0]];
               default: ;
            endcase
            active <= 1'b0;
         end else begin
            step <= step + 2'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [4:0] a, input logic [15:0] d);
      bus.prog_we    = 1'b1;
      bus.prog_addr  = a;
      bus.prog_wdata = d;
      tick();
      bus.prog_we    = 1'b0;
   endtask

   task automatic load_prog_a();
      load_word(5'd0, 16'h0040);
      load_word(5'd1, 16'h0005);
      load_word(5'd2, 16'h0048);
      load_word(5'd3, 16'h0003);
      load_word(5'd4, 16'h0081);
   endtask

   task automatic launch(input logic [5:0] len);
      bus.prog_len = len;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   task automatic wait_halt(input string tag, input int maxc, output int n);
      n = 0;
      while (!bus.halted && n < maxc) begin
         tick();
         n++;
      end
      chk(tag, bus.halted, 1'b1);
   endtask

   function automatic logic [63:0] outs();
      return {bus.DIN, bus.Run, bus.busy, bus.halted, bus.err_mvi, bus.timeout, bus.pc, bus.instr_count};
   endfunction

   initial begin
      int          n;
      logic [9:0]  runs;
      rst            = 1'b1;
      hang           = 1'b0;
      bus.start      = 1'b0;
      bus.prog_we    = 1'b0;
      bus.prog_addr  = '0;
      bus.prog_wdata = '0;
      bus.prog_len   = '0;
      tick();
      tick();
      chk("reset_outs", outs(), 64'd0);
      rst = 1'b0;

      // Program A: mvi R0,#5; mvi R1,#3; add R0,R1
      load_prog_a();
      launch(6'd5);
      chk("a_issue_din", bus.DIN, 16'h0040);
      chk("a_issue_run", bus.Run, 1'b1);
      chk("a_issue_busy", bus.busy, 1'b1);
      chk("a_issue_pc", bus.pc, 6'd0);
      tick();
      chk("a_imm_din", bus.DIN, 16'h0005);
      chk("a_imm_run", bus.Run, 1'b0);
      chk("a_imm_pc", bus.pc, 6'd1);
      wait_halt("a_halt", 40, n);
      chk("a_cycles", n, 6);
      chk("a_r0", R[0], 16'd8);
      chk("a_r1", R[1], 16'd3);
      chk("a_count", bus.instr_count, 16'd3);
      chk("a_pc_end", bus.pc, 6'd5);
      chk("a_busy_end", bus.busy, 1'b0);

      // Four back-to-back mv R1,R0
      for (int i = 0; i < 4; i++) load_word(5'(i), 16'h0008);
      launch(6'd4);
      runs = '0;
      for (int i = 0; i < 10; i++) begin
         runs[i] = bus.Run;
         tick();
      end
      chk("b2b_run_pattern", runs, 10'b00_0101_0101);
      chk("b2b_halted", bus.halted, 1'b1);
      chk("b2b_count", bus.instr_count, 16'd4);
      chk("b2b_pc", bus.pc, 6'd4);
      chk("b2b_r1", R[1], 16'd8);

      // mvi as the only word
      load_word(5'd0, 16'h0040);
      launch(6'd1);
      chk("mvi_last_run", bus.Run, 1'b0);
      chk("mvi_last_err_pre", bus.err_mvi, 1'b0);
      tick();
      chk("mvi_last_err", bus.err_mvi, 1'b1);
      chk("mvi_last_halt", bus.halted, 1'b1);
      chk("mvi_last_run2", bus.Run, 1'b0);
      chk("mvi_last_count", bus.instr_count, 16'd0);

      // Reset in the WAIT of the add
      load_prog_a();
      launch(6'd5);
      chk("rst_err_cleared", bus.err_mvi, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      chk("rst_wait_busy", bus.busy, 1'b1);
      chk("rst_wait_din", bus.DIN, 16'h0081);
      chk("rst_wait_run", bus.Run, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_outs", outs(), 64'd0);

      // Empty program from IDLE
      launch(6'd0);
      chk("len0_halted", bus.halted, 1'b1);
      chk("len0_busy", bus.busy, 1'b0);
      chk("len0_run", bus.Run, 1'b0);

      launch(6'd5);
      chk("rerun_din", bus.DIN, 16'h0040);
      wait_halt("rerun_halt", 40, n);
      chk("rerun_r0", R[0], 16'd8);
      chk("rerun_count", bus.instr_count, 16'd3);
      chk("rerun_pc", bus.pc, 6'd5);

      // Write attempted while busy must be dropped
      launch(6'd5);
      bus.prog_we    = 1'b1;
      bus.prog_addr  = 5'd0;
      bus.prog_wdata = 16'hFFFF;
      tick();
      bus.prog_we    = 1'b0;
      wait_halt("busy_we_halt", 40, n);
      launch(6'd5);
      chk("busy_we_readback", bus.DIN, 16'h0040);
      wait_halt("busy_we_halt2", 40, n);
      chk("busy_we_r0", R[0], 16'd8);

      // Write and start in the same cycle
      bus.prog_we    = 1'b1;
      bus.prog_addr  = 5'd0;
      bus.prog_wdata = 16'h0008;
      launch(6'd1);
      bus.prog_we    = 1'b0;
      chk("we_start_din", bus.DIN, 16'h0008);
      chk("we_start_run", bus.Run, 1'b1);
      wait_halt("we_start_halt", 20, n);
      chk("we_start_r1", R[1], 16'd8);

      // Processor never answers
      load_word(5'd0, 16'h0081);
      hang = 1'b1;
      launch(6'd1);
      for (int i = 0; i < 8; i++) tick();
      chk("wdt_t8_busy", bus.busy, 1'b1);
      chk("wdt_t8_timeout", bus.timeout, 1'b0);
      tick();
`ifdef SEQ_WATCHDOG_EN
      chk("wdt_timeout", bus.timeout, 1'b1);
      chk("wdt_halted", bus.halted, 1'b1);
      chk("wdt_din", bus.DIN, 16'h0000);
`else
      for (int i = 0; i < 20; i++) tick();
      chk("nowdt_busy", bus.busy, 1'b1);
      chk("nowdt_timeout", bus.timeout, 1'b0);
      chk("nowdt_halted", bus.halted, 1'b0);
`endif
      rst  = 1'b1;
      hang = 1'b0;
      tick();
      rst  = 1'b0;
      chk("final_reset_outs", outs(), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
